// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   op_e    - 3-bit operation select
//   flags_t - status flags carried alongside each result
package alu_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_ACC  = 3'b101,
        OP_LDA  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_core: purely combinational ALU datapath.
//   a, b    - operands (a = i1, b = i2)
//   acc     - current accumulator value
//   op      - operation select
//   result  - operation result
//   flags   - carry/borrow, zero, signed overflow
//   acc_we  - op writes its result into the accumulator (ACC, LDA)
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output flags_t           flags,
    output logic             acc_we
);

    // One extra bit so the top bit is the carry (add) or borrow (sub).
    logic [WIDTH:0] sum_ab;
    logic [WIDTH:0] diff_ab;
    logic [WIDTH:0] sum_acc;

    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} - {1'b0, b};
    assign sum_acc = {1'b0, acc} + {1'b0, a};

    always_comb begin
        result = '0;
        flags  = '0;
        acc_we = 1'b0;
        case (op)
            OP_ADD: begin
                result         = sum_ab[WIDTH-1:0];
                flags.carry    = sum_ab[WIDTH];
                flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                                 (sum_ab[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result         = diff_ab[WIDTH-1:0];
                flags.carry    = diff_ab[WIDTH];
                flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                                 (diff_ab[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ACC: begin
                result         = sum_acc[WIDTH-1:0];
                flags.carry    = sum_acc[WIDTH];
                flags.overflow = (acc[WIDTH-1] == a[WIDTH-1]) &&
                                 (sum_acc[WIDTH-1] != acc[WIDTH-1]);
                acc_we         = 1'b1;
            end
            OP_LDA: begin
                result = a;
                acc_we = 1'b1;
            end
            OP_PASS: result = acc;
            default: result = '0;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with an accumulator.
//   clk, rst            - clock, async active-high reset
//   in_valid/in_ready   - operation handshake (i1, i2, opcode)
//   out_valid/out_ready - result handshake (o1, carry, zero, overflow)
//   acc                 - current accumulator value
// S1 holds operands, S2 holds result + flags. The accumulator is updated
// as an op moves S1->S2, so the next op in S1 always sees a current acc.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [OPW-1:0]   opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o1,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] acc
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    flags_t           s2_flags_q, s2_flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2_ready;
    logic             accept;
    logic             s1_move;
    logic [WIDTH-1:0] core_res;
    flags_t           core_flags;
    logic             core_acc_we;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .acc    (acc_q),
        .op     (s1_op_q),
        .result (core_res),
        .flags  (core_flags),
        .acc_we (core_acc_we)
    );

    // No skid buffer: in_ready depends combinationally on out_ready.
    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign accept   = in_valid && in_ready;
    assign s1_move  = s1_valid_q && s2_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_flags_d = s2_flags_q;
        acc_d      = acc_q;

        // S2 either takes S1's op or drains; otherwise it holds while stalled.
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d   = core_res;
                s2_flags_d = core_flags;
                if (core_acc_we) acc_d = core_res;
            end
        end

        if (s1_move) s1_valid_d = 1'b0;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = i1;
            s1_b_d     = i2;
            s1_op_d    = op_e'(opcode);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
            acc_q      <= acc_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign o1        = s2_res_q;
    assign carry     = s2_flags_q.carry;
    assign zero      = s2_flags_q.zero;
    assign overflow  = s2_flags_q.overflow;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8).
// Inputs are driven on the falling edge; handshakes are evaluated 1 time
// unit later, before the next rising edge, so both sides see the same values.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] i1 = '0;
    logic [W-1:0] i2 = '0;
    logic [2:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] o1;
    logic         carry, zero, overflow;
    logic [W-1:0] acc;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i1(i1), .i2(i2), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .o1(o1), .carry(carry), .zero(zero),
        .overflow(overflow), .acc(acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o1;
        logic         c;
        logic         z;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t     sb[$];
    int       n_cmp = 0;
    int       n_err = 0;
    int       cyc = 0;
    logic     lat_strict = 1'b0;
    logic [W-1:0] m_acc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: result/flags of one op against the model accumulator.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, output exp_t e);
        int unsigned s;
        logic [W-1:0] r;
        e.c = 1'b0; e.v = 1'b0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b); r = s[W-1:0]; e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                r = a - b; e.c = (a < b);
                e.v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                s = int'(m_acc) + int'(a); r = s[W-1:0]; e.c = s[W];
                e.v = (m_acc[W-1] == a[W-1]) && (r[W-1] != m_acc[W-1]);
                m_acc = r;
            end
            3'd6: begin r = a; m_acc = a; end
            default: r = m_acc;
        endcase
        e.o1 = r;
        e.z  = (r == '0);
    endtask

    // One clock cycle. If use_exp, the pushed expectation is the given
    // literal instead of the model output (model acc is still advanced).
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic ordy,
                        input logic use_exp, input exp_t ex, output logic fired);
        exp_t e, p;
        @(negedge clk);
        in_valid = iv; i1 = a; i2 = b; opcode = op; out_ready = ordy;
        #1;
        cyc++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else begin
                p = sb.pop_front();
                chk("o1", 32'(o1), 32'(p.o1));
                chk("carry", 32'(carry), 32'(p.c));
                chk("zero", 32'(zero), 32'(p.z));
                chk("overflow", 32'(overflow), 32'(p.v));
                if (lat_strict) chk("latency", cyc - p.cyc, 2);
            end
        end
        fired = in_valid && in_ready;
        if (fired) begin
            model(a, b, op, e);
            if (use_exp) begin e.o1 = ex.o1; e.c = ex.c; e.z = ex.z; e.v = ex.v; end
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t d;
        logic f;
        d = '{default: 0};
        for (int k = 0; k < 40 && sb.size() != 0; k++)
            step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, d, f);
        chk("drain_left", sb.size(), 0);
    endtask

    // Directed table: a, b, op, expected o1, carry, zero, overflow.
    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   op;
        logic [W-1:0] r;
        logic         c, z, v;
    } vec_t;

    vec_t dir_tbl[13] = '{
        '{8'd5,   8'd10,  3'd0, 8'd15,  1'b0, 1'b0, 1'b0},
        '{8'd100, 8'd77,  3'd1, 8'd23,  1'b0, 1'b0, 1'b0},
        '{8'd10,  8'd25,  3'd1, 8'd241, 1'b1, 1'b0, 1'b0},
        '{8'd127, 8'd1,   3'd0, 8'd128, 1'b0, 1'b0, 1'b1},
        '{8'd200, 8'd88,  3'd0, 8'd32,  1'b1, 1'b0, 1'b0},
        '{8'hF0,  8'h3C,  3'd2, 8'h30,  1'b0, 1'b0, 1'b0},
        '{8'hF0,  8'h3C,  3'd3, 8'hFC,  1'b0, 1'b0, 1'b0},
        '{8'hAA,  8'hAA,  3'd4, 8'h00,  1'b0, 1'b1, 1'b0},
        '{8'd10,  8'd0,   3'd6, 8'd10,  1'b0, 1'b0, 1'b0},
        '{8'd25,  8'd0,   3'd5, 8'd35,  1'b0, 1'b0, 1'b0},
        '{8'd1,   8'd0,   3'd5, 8'd36,  1'b0, 1'b0, 1'b0},
        '{8'd0,   8'd0,   3'd7, 8'd36,  1'b0, 1'b0, 1'b0},
        '{8'd128, 8'd1,   3'd1, 8'd127, 1'b0, 1'b0, 1'b1}
    };

    initial begin
        exp_t  ex;
        logic  f;
        int    idx;
        int    n_acc;
        logic [W-1:0] held_o1;

        ex = '{default: 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_o1", 32'(o1), 0);
        chk("rst_flags", {29'd0, carry, zero, overflow}, 0);
        rst = 1'b0;

        // Directed stream, back-to-back, out_ready high: fixed 2-cycle latency
        lat_strict = 1'b1;
        for (int k = 0; k < 13; k++) begin
            ex.o1 = dir_tbl[k].r; ex.c = dir_tbl[k].c;
            ex.z = dir_tbl[k].z; ex.v = dir_tbl[k].v;
            step(1'b1, dir_tbl[k].a, dir_tbl[k].b, dir_tbl[k].op, 1'b1, 1'b1, ex, f);
            chk("stream_accept", 32'(f), 1);
        end
        drain();
        chk("acc_after_stream", 32'(acc), 36);
        lat_strict = 1'b0;

        // Backpressure: out_ready low for 5 cycles while offering 4 ops
        idx = 0;
        held_o1 = '0;
        for (int k = 0; k < 60 && (idx < 4 || sb.size() != 0); k++) begin
            step(idx < 4, 8'(idx * 3 + 1), 8'(idx + 7), 3'd0, k >= 5, 1'b0, ex, f);
            if (k >= 2 && k <= 4) chk("bp_in_ready_low", 32'(in_ready), 0);
            if (k == 2) begin
                chk("bp_out_valid", 32'(out_valid), 1);
                held_o1 = o1;
            end
            if (k == 3 || k == 4) chk("bp_o1_stable", 32'(o1), 32'(held_o1));
            if (f) idx++;
        end
        chk("bp_all_accepted", idx, 4);
        chk("bp_all_retired", sb.size(), 0);

        // Reset mid-stream with two ops in flight
        step(1'b1, 8'd55, 8'd0, 3'd6, 1'b1, 1'b0, ex, f);
        step(1'b1, 8'd1, 8'd2, 3'd0, 1'b1, 1'b0, ex, f);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_acc", 32'(acc), 0);
        sb.delete();
        m_acc = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, ex, f);
        lat_strict = 1'b1;
        ex.o1 = 8'd9; ex.c = 1'b0; ex.z = 1'b0; ex.v = 1'b0;
        step(1'b1, 8'd4, 8'd5, 3'd0, 1'b1, 1'b1, ex, f);
        drain();
        lat_strict = 1'b0;

        // Random traffic with random backpressure
        n_acc = 0;
        for (int k = 0; k < 20000 && n_acc < 1000; k++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 1'b0, ex, f);
            if (f) n_acc++;
        end
        chk("rand_accepts", n_acc, 1000);
        drain();
        chk("rand_acc", 32'(acc), 32'(m_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 8-bit combinational ALU. Two register stages with a valid/ready handshake on both sides. Adds status flags, an internal accumulator with accumulate/load modes, and full backpressure. Sits between an operand producer (sequencer or bench driver) and a result consumer. Each accepted operation retires exactly once, in order.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- i1  in  WIDTH  operand A
- i2  in  WIDTH  operand B
- opcode  in  3  operation select (alu_pkg::op_e)
- out_valid  out  1  result presented
- out_ready  in  1  consumer takes result when out_valid && out_ready
- o1  out  WIDTH  result
- carry  out  1  carry-out (add/acc) or borrow (sub), else 0
- zero  out  1  o1 == 0
- overflow  out  1  signed overflow (add/sub/acc), else 0
- acc  out  WIDTH  current accumulator value

## Operation
- Opcodes:
  - 000 ADD: i1+i2
  - 001 SUB: i1−i2
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 ACC: acc+i1; result also written to acc
  - 110 LDA: acc←i1; result = i1
  - 111 PASS: result = acc, acc unchanged
- Arithmetic is done at WIDTH+1 bits. carry = bit WIDTH of the sum. For SUB, carry = 1 iff i1 < i2 (unsigned borrow).
- overflow: ADD/ACC set it when operands share a sign and the result sign differs. SUB sets it when operand signs differ and the result sign differs from i1.
- Stage 1 (S1) registers i1, i2, opcode on handshake.
- Stage 2 (S2) registers result and flags computed from S1 and the current acc.
- acc updates when an ACC or LDA op moves S1→S2. Back-to-back ACC ops therefore see each other's results with no hazard.
- Output o1/carry/zero/overflow come straight from S2 registers and stay stable while out_valid && !out_ready.
- Reset values: in_ready 1; out_valid 0; o1 0; carry 0; zero 0; overflow 0; acc 0; both stage valid bits 0.

## Timing
- Latency: 2 cycles from accept edge to out_valid, with out_ready held high.
- Throughput: 1 op/cycle with no backpressure.
- s2_ready = !s2_valid || out_ready.
- in_ready = !s1_valid || s2_ready. It is combinational from out_ready; there is no skid buffer.
- Stall: with out_ready low and both stages full, in_ready = 0. S1 and S2 contents, and acc, are held unchanged.
- Simultaneous accept and retire in the same cycle is legal and loses nothing.
- in_valid without in_ready: inputs are ignored and no state changes.
- rst asserted mid-operation flushes both stages immediately: out_valid drops asynchronously and acc clears. After rst deasserts, the first op accepted on the next edge appears 2 cycles later.
- zero is evaluated on the registered result, including for PASS and LDA.

## Structure
- Package alu_pkg holds:
  - typedef enum logic [2:0] op_e (OP_ADD … OP_PASS)
  - localparam OPW = 3
  - a struct for flags {carry, zero, overflow}
- Sub-module alu_core (purely combinational, parameter WIDTH) takes a, b, acc, op and returns result, flags, and acc_we.
- alu_pipe contains only the two stage registers, the acc register, and handshake logic.

## Test plan
All scenarios use WIDTH=8.
- Reset: after rst pulse → out_valid=0, acc=0, in_ready=1. rst mid-stream with two ops in flight → no result emerges and acc=0.
- Streaming, out_ready=1:
  - ADD 5+10 → o1=15 two cycles after accept
  - SUB 100−77 → 23, carry=0
  - SUB 10−25 → 241, carry=1
  - ADD 127+1 → 128, overflow=1
  - ADD 200+88 → 32, carry=1
  - one result per cycle
- Logic ops: AND 8'hF0&8'h3C → 8'h30; OR → 8'hFC; XOR 8'hAA^8'hAA → 0 with zero=1.
- Accumulator: LDA 10, ACC 25, ACC 1, PASS issued back-to-back → results 10, 35, 36, 36; acc=36.
- Backpressure: out_ready=0 for 5 cycles during a stream of 4 ops. in_ready falls after 2 accepts, o1 stays stable, and after release all 4 results arrive in order with none duplicated.
- Random: 1000 random ops with random in_valid/out_ready, checked against a scoreboard model of op order and acc.
